// File: rtl/if_id_stage_reg.sv
// Elastic IF/ID pipeline register with valid/ready handshake, optional 2-entry skid and flush-to-NOP.
// Optional stall counter port/logic enabled by defining PIPE_STAGE_STALL_CNT_EN.
module if_id_stage_reg #(
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter bit                 SKID      = 1'b1,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  logic accept;
  logic deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_e;

    state_e             state;
    state_e             state_nxt;
    logic               load_in;
    logic               load_skid;
    logic               skid_to_out;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    // Next state and datapath steering; flush overrides every move
    always_comb begin
      state_nxt   = state;
      load_in     = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      unique case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_FULL;
            load_in   = 1'b1;
          end
        end
        S_FULL: begin
          if (accept && deliver) begin
            load_in = 1'b1;
          end else if (deliver) begin
            state_nxt = S_EMPTY;
          end else if (accept) begin
            state_nxt = S_SKID;
            load_skid = 1'b1;
          end
        end
        S_SKID: begin
          if (deliver) begin
            state_nxt   = S_FULL;
            skid_to_out = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
      if (flush) begin
        state_nxt   = S_EMPTY;
        load_in     = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
      end
    end

    // in_ready and out_valid are registered copies of the next-state decode
    always_ff @(posedge clk) begin
      if (rst) begin
        state      <= S_EMPTY;
        in_ready   <= 1'b1;
        out_valid  <= 1'b0;
        out_pc     <= '0;
        out_instr  <= NOP_INSTR;
        skid_pc    <= '0;
        skid_instr <= NOP_INSTR;
      end else begin
        state     <= state_nxt;
        in_ready  <= (state_nxt != S_SKID);
        out_valid <= (state_nxt != S_EMPTY);
        if (flush) begin
          out_instr <= NOP_INSTR;
        end else if (load_in) begin
          out_pc    <= in_pc;
          out_instr <= in_instr;
        end else if (skid_to_out) begin
          out_pc    <= skid_pc;
          out_instr <= skid_instr;
        end
        if (load_skid) begin
          skid_pc    <= in_pc;
          skid_instr <= in_instr;
        end
      end
    end
  end else begin : g_single
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_pc    <= '0;
        out_instr <= NOP_INSTR;
      end else if (flush) begin
        out_valid <= 1'b0;
        out_instr <= NOP_INSTR;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_instr <= in_instr;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating count of back-pressured cycles; survives flush
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: SKID=1 and SKID=0 instances driven in lockstep, scoreboard per instance.
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_pc1, out_instr1, out_pc0, out_instr0;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [3:0]  stall_cnt1, stall_cnt0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  word_t q1[$];
  word_t q0[$];

  always #5 clk = ~clk;

  if_id_stage_reg #(.NOP_INSTR(NOP), .SKID(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1), .out_instr(out_instr1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  if_id_stage_reg #(.NOP_INSTR(NOP), .SKID(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0), .out_instr(out_instr0)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reset held for n edges with a valid word offered; everything in flight is dropped
  task automatic do_reset(input int n);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 32'hBAD0; in_instr = 32'hBAD1; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    q1.delete();
    q0.delete();
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_in_ready1", in_ready1, 1);
    chk("rst_out_pc1", out_pc1, 0);
    chk("rst_out_instr1", out_instr1, NOP);
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_out_pc0", out_pc0, 0);
    chk("rst_out_instr0", out_instr0, NOP);
  endtask

  // One clock: drive, check against the models at negedge, then update the scoreboards
  task automatic cyc(input logic v, input logic [31:0] pc, input logic r, input logic f);
    logic acc1, acc0, del1, del0;
    in_valid = v; in_pc = pc; in_instr = pc ^ 32'hC0DE_0000; out_ready = r; flush = f;
    @(negedge clk);
    chk("in_ready1", in_ready1, (q1.size() < 2) ? 1 : 0);
    chk("out_valid1", out_valid1, (q1.size() != 0) ? 1 : 0);
    chk("in_ready0", in_ready0, (q0.size() == 0 || r) ? 1 : 0);
    chk("out_valid0", out_valid0, (q0.size() != 0) ? 1 : 0);
    del1 = (q1.size() != 0) && r;
    del0 = (q0.size() != 0) && r;
    if (del1) begin
      chk("deliver_pc1", out_pc1, q1[0].pc);
      chk("deliver_instr1", out_instr1, q1[0].instr);
    end
    if (del0) begin
      chk("deliver_pc0", out_pc0, q0[0].pc);
      chk("deliver_instr0", out_instr0, q0[0].instr);
    end
    acc1 = v && (q1.size() < 2);
    acc0 = v && (q0.size() == 0 || r);
    @(posedge clk);
    #1;
    if (del1) void'(q1.pop_front());
    if (del0) void'(q0.pop_front());
    if (f) begin
      q1.delete();
      q0.delete();
    end else begin
      if (acc1) q1.push_back('{pc: pc, instr: pc ^ 32'hC0DE_0000});
      if (acc0) q0.push_back('{pc: pc, instr: pc ^ 32'hC0DE_0000});
    end
  endtask

  initial begin
    do_reset(2);

    // Back-to-back stream at full throughput
    cyc(1, 32'h4, 1, 0);
    cyc(1, 32'h8, 1, 0);
    cyc(1, 32'hC, 1, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // Back-pressure fills the skid; single-register variant stalls its input
    cyc(1, 32'h10, 0, 0);
    cyc(1, 32'h14, 0, 0);
    cyc(1, 32'h18, 0, 0);
    chk("held_pc1", out_pc1, 32'h10);
    chk("held_pc0", out_pc0, 32'h10);
    chk("held_valid0", out_valid0, 1);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // Flush while the skid is occupied
    cyc(1, 32'h20, 0, 0);
    cyc(1, 32'h24, 0, 0);
    cyc(1, 32'h28, 0, 1);
    chk("flush_valid1", out_valid1, 0);
    chk("flush_ready1", in_ready1, 1);
    chk("flush_instr1", out_instr1, NOP);
    chk("flush_pc1", out_pc1, 32'h20);
    chk("flush_instr0", out_instr0, NOP);
    chk("flush_pc0", out_pc0, 32'h20);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // Flush together with out_ready: current word delivered, incoming discarded
    cyc(1, 32'h30, 1, 0);
    cyc(1, 32'h34, 1, 1);
    cyc(0, 32'h0, 1, 0);
    chk("flush_rdy_instr1", out_instr1, NOP);

`ifdef PIPE_STAGE_STALL_CNT_EN
    cyc(1, 32'h40, 0, 0);
    repeat (20) cyc(0, 32'h0, 0, 0);
    chk("stall_sat1", 32'(stall_cnt1), 15);
    chk("stall_sat0", 32'(stall_cnt0), 15);
    cyc(0, 32'h0, 0, 1);
    chk("stall_flush1", 32'(stall_cnt1), 15);
    chk("stall_flush0", 32'(stall_cnt0), 15);
    do_reset(1);
    chk("stall_rst1", 32'(stall_cnt1), 0);
    chk("stall_rst0", 32'(stall_cnt0), 0);
`endif

    // Random traffic with occasional flushes
    for (int i = 0; i < 80; i++) begin
      cyc(1'($urandom_range(0, 1)), 32'h100 + 32'(i) * 4, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end
    repeat (3) cyc(0, 32'h0, 1, 0);

    // Reset mid-stream discards in-flight words
    cyc(1, 32'h200, 0, 0);
    cyc(1, 32'h204, 0, 0);
    do_reset(1);
    cyc(1, 32'h300, 1, 0);
    cyc(0, 32'h0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
